// File: rtl/sd_adc_ear.sv
// First-order 1-bit sigma-delta ADC front end for the EAR/line input.
// Closes the comparator loop through fb_out and decimates the bitstream into 8-bit excess-128 samples.
module sd_adc_ear #(
    parameter int         DECIM_LOG2 = 8,
    parameter logic [7:0] HYST_HI    = 8'd144,
    parameter logic [7:0] HYST_LO    = 8'd112
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       cmp_in,
    (* IOB = "TRUE" *)
    output logic       fb_out,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       ear_out
);

    localparam int ACC_W = DECIM_LOG2 + 1;
    localparam int SHIFT = DECIM_LOG2 - 8;

    typedef enum logic {
        WARMUP,
        RUN
    } state_t;

    logic                  sync1;
    logic                  sync2;
    logic [ACC_W-1:0]      acc;
    logic [DECIM_LOG2-1:0] win_cnt;
    state_t                state;

    logic                  win_end;
    logic [ACC_W-1:0]      total;
    logic [7:0]            new_sample;

    // A full window of ones scales to 256, one past the 8-bit range, so clamp it to 255.
    function automatic logic [7:0] sat_sample(input logic [ACC_W-1:0] t);
        logic [ACC_W-1:0] scaled;
        scaled = t >> SHIFT;
        if (|(scaled >> 8))
            return 8'hFF;
        else
            return scaled[7:0];
    endfunction

    // The current fb_out is folded into the total so the window-end bit lands in this window.
    assign win_end    = (win_cnt == {DECIM_LOG2{1'b1}});
    assign total      = acc + {{DECIM_LOG2{1'b0}}, fb_out};
    assign new_sample = sat_sample(total);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            fb_out       <= 1'b0;
            acc          <= '0;
            win_cnt      <= '0;
            state        <= WARMUP;
            sample       <= 8'h80;
            sample_valid <= 1'b0;
            ear_out      <= 1'b0;
        end else begin
            sync1        <= cmp_in;
            sync2        <= sync1;
            fb_out       <= sync2;
            win_cnt      <= win_cnt + 1'b1;
            sample_valid <= 1'b0;

            if (win_end) begin
                acc <= '0;
                // The first window is thrown away while the RC integrator settles.
                if (state == WARMUP) begin
                    state <= RUN;
                end else begin
                    sample       <= new_sample;
                    sample_valid <= 1'b1;
                    if (new_sample >= HYST_HI)
                        ear_out <= 1'b1;
                    else if (new_sample <= HYST_LO)
                        ear_out <= 1'b0;
                end
            end else begin
                acc <= total;
            end
        end
    end

endmodule

// File: tb/tb_sd_adc_ear.sv
// Directed bench for sd_adc_ear: one instance at DECIM_LOG2=8 and one at DECIM_LOG2=10.
// cmp_in follows periodic patterns so every window holds a known number of ones regardless of alignment.
module tb_sd_adc_ear;

    localparam int M_ZERO   = 0;
    localparam int M_ONE    = 1;
    localparam int M_BURST  = 2;
    localparam int M_SINGLE = 3;

    logic       clk = 1'b0;
    logic       rst_a, cmp_a, fb_a, vld_a, ear_a;
    logic       rst_b, cmp_b, fb_b, vld_b, ear_b;
    logic [7:0] smp_a, smp_b;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int sel    = 0;
    int mode   = M_ZERO;
    int p_period = 256;
    int p_start  = 0;
    int p_ones   = 0;

    always #5 clk = ~clk;

    sd_adc_ear dut_a (
        .Clk          (clk),
        .Reset        (rst_a),
        .cmp_in       (cmp_a),
        .fb_out       (fb_a),
        .sample       (smp_a),
        .sample_valid (vld_a),
        .ear_out      (ear_a)
    );

    sd_adc_ear #(.DECIM_LOG2(10)) dut_b (
        .Clk          (clk),
        .Reset        (rst_b),
        .cmp_in       (cmp_b),
        .fb_out       (fb_b),
        .sample       (smp_b),
        .sample_valid (vld_b),
        .ear_out      (ear_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s edge %0d observed %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    function automatic logic pat(input int e);
        case (mode)
            M_ONE:    return 1'b1;
            M_BURST:  return ((e % p_period) >= p_start) && ((e % p_period) < p_start + p_ones);
            M_SINGLE: return e == p_start;
            default:  return 1'b0;
        endcase
    endfunction

    // Sets the value that the next rising edge (edge_n+1) samples.
    task automatic drive();
        if (sel == 0) cmp_a = pat(edge_n + 1);
        else          cmp_b = pat(edge_n + 1);
    endtask

    task automatic set_pat(input int m, input int period, input int start, input int ones);
        mode     = m;
        p_period = period;
        p_start  = start;
        p_ones   = ones;
        drive();
    endtask

    task automatic adv_to(input int target);
        int  win;
        logic exp_vld;
        win = (sel == 0) ? 256 : 1024;
        while (edge_n < target) begin
            @(negedge clk);
            edge_n++;
            drive();
            exp_vld = (edge_n % win == 0) && (edge_n >= 2 * win);
            check("valid", {7'd0, (sel == 0) ? vld_a : vld_b}, {7'd0, exp_vld});
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] s, input logic e);
        check({tag, "_sample"}, (sel == 0) ? smp_a : smp_b, s);
        check({tag, "_ear"}, {7'd0, (sel == 0) ? ear_a : ear_b}, {7'd0, e});
    endtask

    task automatic reset_dut();
        if (sel == 0) rst_a = 1'b1;
        else          rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_sample", (sel == 0) ? smp_a : smp_b, 8'h80);
        check("rst_valid", {7'd0, (sel == 0) ? vld_a : vld_b}, 8'd0);
        check("rst_ear", {7'd0, (sel == 0) ? ear_a : ear_b}, 8'd0);
        check("rst_fb", {7'd0, (sel == 0) ? fb_a : fb_b}, 8'd0);
        if (sel == 0) rst_a = 1'b0;
        else          rst_b = 1'b0;
        edge_n = 0;
        drive();
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        cmp_a = 1'b0;
        cmp_b = 1'b0;
        repeat (2) @(negedge clk);

        // DECIM_LOG2=8: all ones, first pulse at edge 512, saturated to 255.
        sel = 0;
        mode = M_ONE;
        reset_dut();
        adv_to(2);
        check("fb_e2", {7'd0, fb_a}, 8'd0);
        adv_to(3);
        check("fb_e3", {7'd0, fb_a}, 8'd1);
        adv_to(512);
        check_out("ones", 8'd255, 1'b1);

        // All zeros; the straddling window still holds the last three ones.
        set_pat(M_ZERO, 256, 0, 0);
        adv_to(768);
        check_out("zero_mix", 8'd3, 1'b0);
        adv_to(1024);
        check_out("zeros", 8'd0, 1'b0);

        // Toggle every clock: 128 per window, ear_out holds inside the band.
        set_pat(M_BURST, 2, 0, 1);
        adv_to(1280);
        check_out("tog_mix", 8'd126, 1'b0);
        adv_to(1536);
        check_out("toggle", 8'd128, 1'b0);

        set_pat(M_BURST, 256, 3, 150);
        adv_to(2048);
        check_out("d150", 8'd150, 1'b1);
        set_pat(M_BURST, 256, 3, 120);
        adv_to(2304);
        check_out("d120", 8'd120, 1'b1);

        // Reset at win_cnt=100 of a RUN window, then 150 ones per window.
        set_pat(M_BURST, 256, 3, 150);
        adv_to(2404);
        reset_dut();
        adv_to(512);
        check_out("post_rst", 8'd150, 1'b1);

        set_pat(M_BURST, 256, 3, 100);
        adv_to(767);
        check_out("pre100", 8'd150, 1'b1);
        adv_to(768);
        check_out("d100", 8'd100, 1'b0);

        // One 1 on cmp_in at edge 1021 reaches fb_out only for the window-end edge 1024.
        set_pat(M_SINGLE, 256, 1021, 0);
        adv_to(1023);
        check("fb_single", {7'd0, fb_a}, 8'd1);
        adv_to(1024);
        check("fb_after", {7'd0, fb_a}, 8'd0);
        check_out("bound", 8'd1, 1'b0);
        adv_to(1280);
        check_out("bound_next", 8'd0, 1'b0);

        // DECIM_LOG2=10 instance.
        sel = 1;
        mode = M_ONE;
        reset_dut();
        adv_to(2048);
        check_out("w10_ones", 8'd255, 1'b1);
        set_pat(M_BURST, 2, 0, 1);
        adv_to(3072);
        check_out("w10_mix", 8'd128, 1'b1);
        adv_to(4096);
        check_out("w10_half", 8'd128, 1'b1);
        set_pat(M_BURST, 1024, 3, 3);
        adv_to(5120);
        check_out("w10_mix3", 8'd1, 1'b0);
        adv_to(6144);
        check_out("w10_three", 8'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
